// File: rtl/apb_rr_master.sv
// Two-requester APB master with round-robin arbitration.
// Each granted request becomes one APB SETUP/ACCESS transfer. ACCESS waits on
// pready_i with a wait-state timeout, and the result (read data, error) is
// returned to the requester that owns the transfer with a one-cycle done pulse.
module apb_rr_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Last wait count before abort: the ACCESS cycle that would make the count
  // reach TIMEOUT is the one that aborts.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              ptr;          // requester that wins a tie
  logic              ptr_nxt;
  logic              owner;        // requester owning the current transfer
  logic              owner_nxt;
  logic [7:0]        wait_cnt;
  logic [7:0]        wait_cnt_nxt;
  logic              winner;

  logic              gnt0_nxt;
  logic              gnt1_nxt;
  logic              done0_nxt;
  logic              done1_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              err_nxt;
  logic              psel_nxt;
  logic              penable_nxt;
  logic              pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;

  // Arbitration: a lone request wins outright, a tie goes to the pointer.
  always_comb begin
    winner = 1'b0;
    if (req0_i && req1_i) begin
      winner = ptr;
    end else if (req1_i) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    wait_cnt_nxt = wait_cnt;
    gnt0_nxt     = 1'b0;
    gnt1_nxt     = 1'b0;
    done0_nxt    = 1'b0;
    done1_nxt    = 1'b0;
    rdata_nxt    = {DATA_W{1'b0}};
    err_nxt      = 1'b0;
    psel_nxt     = psel_o;
    penable_nxt  = penable_o;
    pwrite_nxt   = pwrite_o;
    paddr_nxt    = paddr_o;
    pwdata_nxt   = pwdata_o;

    case (state)
      IDLE: begin
        if (req0_i || req1_i) begin
          owner_nxt   = winner;
          ptr_nxt     = ~winner;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
          if (winner) begin
            gnt1_nxt   = 1'b1;
            pwrite_nxt = we1_i;
            paddr_nxt  = addr1_i;
            pwdata_nxt = wdata1_i;
          end else begin
            gnt0_nxt   = 1'b1;
            pwrite_nxt = we0_i;
            paddr_nxt  = addr0_i;
            pwdata_nxt = wdata0_i;
          end
        end else begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
        end
      end

      SETUP: begin
        penable_nxt  = 1'b1;
        wait_cnt_nxt = 8'd0;
        state_nxt    = ACCESS;
      end

      ACCESS: begin
        if (pready_i) begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          done0_nxt   = ~owner;
          done1_nxt   = owner;
          err_nxt     = pslverr_i;
          rdata_nxt   = pwrite_o ? {DATA_W{1'b0}} : prdata_i;
          state_nxt   = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          // Slave stalled for TIMEOUT cycles: abort with error, no data.
          wait_cnt_nxt = wait_cnt + 8'd1;
          psel_nxt     = 1'b0;
          penable_nxt  = 1'b0;
          done0_nxt    = ~owner;
          done1_nxt    = owner;
          err_nxt      = 1'b1;
          state_nxt    = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end

      default: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // FSM, arbitration and bookkeeping registers.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Registered outputs toward requesters and the APB slave.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      gnt0_o    <= 1'b0;
      gnt1_o    <= 1'b0;
      done0_o   <= 1'b0;
      done1_o   <= 1'b0;
      rdata_o   <= {DATA_W{1'b0}};
      err_o     <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= {ADDR_W{1'b0}};
      pwdata_o  <= {DATA_W{1'b0}};
    end else begin
      gnt0_o    <= gnt0_nxt;
      gnt1_o    <= gnt1_nxt;
      done0_o   <= done0_nxt;
      done1_o   <= done1_nxt;
      rdata_o   <= rdata_nxt;
      err_o     <= err_nxt;
      psel_o    <= psel_nxt;
      penable_o <= penable_nxt;
      pwrite_o  <= pwrite_nxt;
      paddr_o   <= paddr_nxt;
      pwdata_o  <= pwdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: a small APB memory slave model, a scoreboard of
// expected completions checked on every done pulse, and one task per scenario.
module tb_apb_rr_master;

  logic        pclk_i = 1'b0;
  logic        prst_i = 1'b1;
  logic        req0_i = 1'b0, req1_i = 1'b0;
  logic        we0_i = 1'b0, we1_i = 1'b0;
  logic [7:0]  addr0_i = 8'd0, addr1_i = 8'd0;
  logic [31:0] wdata0_i = 32'd0, wdata1_i = 32'd0;
  logic        gnt0_o, gnt1_o, done0_o, done1_o, err_o;
  logic [31:0] rdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [7:0]  paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i, pslverr_i;

  logic        stall = 1'b0;
  logic        slverr_inj = 1'b0;
  logic [31:0] mem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb [$];

  apb_rr_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk_i(pclk_i), .prst_i(prst_i),
    .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .done0_o(done0_o), .done1_o(done1_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 pclk_i = ~pclk_i;

  // Memory slave: ready only in ACCESS (unless stalled), write on completion.
  assign pready_i  = !stall && psel_o && penable_o;
  assign pslverr_i = slverr_inj && psel_o && penable_o;
  assign prdata_i  = mem[paddr_o];

  always @(posedge pclk_i) begin
    if (psel_o && penable_o && pready_i && pwrite_o) mem[paddr_o] <= pwdata_o;
  end

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge pclk_i) begin
    if (!prst_i && (done0_o || done1_o)) begin
      exp_t e;
      n_cmp++;
      if (done0_o && done1_o) begin
        n_err++;
        $display("FAIL done_both: done0=%b done1=%b, required one-hot", done0_o, done1_o);
      end
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: done0=%b done1=%b with no pending transfer", done0_o, done1_o);
      end else begin
        e = sb.pop_front();
        n_cmp += 2;
        if (done1_o !== e.owner) begin
          n_err++;
          $display("FAIL done_owner: got owner %b, required %b", done1_o, e.owner);
        end
        if (rdata_o !== e.rdata || err_o !== e.err) begin
          n_err++;
          $display("FAIL done_result: got rdata=%h err=%b, required rdata=%h err=%b",
                   rdata_o, err_o, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    req0_i = 1'b0; req1_i = 1'b0; stall = 1'b0; slverr_inj = 1'b0;
    @(negedge pclk_i); prst_i = 1'b1;
    @(negedge pclk_i); prst_i = 1'b0;
  endtask

  task automatic drive_req(input logic who, input logic we, input logic [7:0] a, input logic [31:0] d);
    if (who) begin
      we1_i = we; addr1_i = a; wdata1_i = d; req1_i = 1'b1;
    end else begin
      we0_i = we; addr0_i = a; wdata0_i = d; req0_i = 1'b1;
    end
  endtask

  // Full handshake for one transfer; the scoreboard checks the result.
  task automatic run_xfer(input logic who, input logic we, input logic [7:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_er);
    bit got;
    sb.push_back('{who, exp_rd, exp_er});
    drive_req(who, we, a, d);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge pclk_i);
      if (who ? gnt1_o : gnt0_o) got = 1'b1;
    end
    if (who) req1_i = 1'b0; else req0_i = 1'b0;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL xfer_gnt: no grant to requester %0d within 20 cycles", who);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge pclk_i);
      if (who ? done1_o : done0_o) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL xfer_done: no done to requester %0d within 40 cycles", who);
    end
  endtask

  task automatic test_reset();
    prst_i = 1'b1;
    @(negedge pclk_i);
    n_cmp++;
    if ({gnt0_o, gnt1_o, done0_o, done1_o, err_o, psel_o, penable_o, pwrite_o} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, required 00000000",
               {gnt0_o, gnt1_o, done0_o, done1_o, err_o, psel_o, penable_o, pwrite_o});
    end
    n_cmp++;
    if (paddr_o !== 8'h00 || pwdata_o !== 32'h0 || rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h, required all 0",
               paddr_o, pwdata_o, rdata_o);
    end
    prst_i = 1'b0;
  endtask

  task automatic test_single_write_read();
    sb.push_back('{1'b0, 32'h0, 1'b0});
    drive_req(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    @(negedge pclk_i);  // N+1: grant, SETUP
    req0_i = 1'b0;
    n_cmp++;
    if ({gnt0_o, gnt1_o, psel_o, penable_o} !== 4'b1010 || paddr_o !== 8'h10 ||
        pwrite_o !== 1'b1 || pwdata_o !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_setup: gnt0/gnt1/psel/pen=%b paddr=%h pwrite=%b pwdata=%h, required 1010 10 1 deadbeef",
               {gnt0_o, gnt1_o, psel_o, penable_o}, paddr_o, pwrite_o, pwdata_o);
    end
    @(negedge pclk_i);  // N+2: ACCESS
    n_cmp++;
    if ({gnt0_o, psel_o, penable_o, done0_o} !== 4'b0110 || paddr_o !== 8'h10 ||
        pwdata_o !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_access: gnt0/psel/pen/done0=%b paddr=%h pwdata=%h, required 0110 10 deadbeef",
               {gnt0_o, psel_o, penable_o, done0_o}, paddr_o, pwdata_o);
    end
    @(negedge pclk_i);  // N+3: done
    n_cmp++;
    if ({done0_o, done1_o, psel_o, penable_o} !== 4'b1000) begin
      n_err++;
      $display("FAIL single_done: done0/done1/psel/pen=%b, required 1000",
               {done0_o, done1_o, psel_o, penable_o});
    end
    run_xfer(1'b0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge pclk_i);
    n_cmp++;
    if (rdata_o !== 32'h0 || err_o !== 1'b0 || done0_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_after_done: rdata=%h err=%b done0=%b, required 0 0 0",
               rdata_o, err_o, done0_o);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    sb.push_back('{1'b0, 32'h0, 1'b0});
    sb.push_back('{1'b1, 32'h0, 1'b0});
    drive_req(1'b0, 1'b1, 8'h01, 32'h0101_AAAA);
    drive_req(1'b1, 1'b1, 8'h02, 32'h0202_5555);
    @(negedge pclk_i);
    req0_i = 1'b0;
    n_cmp++;
    if ({gnt0_o, gnt1_o} !== 2'b10) begin
      n_err++;
      $display("FAIL sim_first_gnt: gnt0/gnt1=%b, required 10", {gnt0_o, gnt1_o});
    end
    @(negedge pclk_i);
    @(negedge pclk_i);
    n_cmp++;
    if ({done0_o, gnt1_o, psel_o} !== 3'b100) begin
      n_err++;
      $display("FAIL sim_idle_gap: done0/gnt1/psel=%b, required 100", {done0_o, gnt1_o, psel_o});
    end
    @(negedge pclk_i);
    req1_i = 1'b0;
    n_cmp++;
    if ({gnt0_o, gnt1_o, paddr_o} !== {2'b01, 8'h02}) begin
      n_err++;
      $display("FAIL sim_second_gnt: gnt0/gnt1=%b paddr=%h, required 01 02", {gnt0_o, gnt1_o}, paddr_o);
    end
    @(negedge pclk_i);
    @(negedge pclk_i);
    run_xfer(1'b1, 1'b0, 8'h01, 32'h0, 32'h0101_AAAA, 1'b0);
    run_xfer(1'b0, 1'b0, 8'h02, 32'h0, 32'h0202_5555, 1'b0);
  endtask

  task automatic test_fairness();
    logic order [$];
    logic exp_own;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      exp_own = k[0];
      sb.push_back('{exp_own, 32'h0, 1'b0});
    end
    drive_req(1'b0, 1'b1, 8'h20, 32'h2000_0000);
    drive_req(1'b1, 1'b1, 8'h21, 32'h2100_0000);
    for (int i = 0; i < 40 && order.size() < 6; i++) begin
      @(negedge pclk_i);
      if (gnt0_o) order.push_back(1'b0);
      if (gnt1_o) order.push_back(1'b1);
      if (order.size() == 6) begin
        req0_i = 1'b0; req1_i = 1'b0;
      end
    end
    req0_i = 1'b0; req1_i = 1'b0;
    n_cmp++;
    if (order.size() != 6) begin
      n_err++;
      $display("FAIL fair_count: got %0d grants, required 6", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      exp_own = k[0];
      n_cmp++;
      if (order[k] !== exp_own) begin
        n_err++;
        $display("FAIL fair_order: grant %0d went to %b, required %b", k, order[k], exp_own);
      end
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge pclk_i);
    @(negedge pclk_i);
  endtask

  task automatic test_slave_error();
    run_xfer(1'b0, 1'b1, 8'h30, 32'hA5A5_0F0F, 32'h0, 1'b0);
    slverr_inj = 1'b1;
    run_xfer(1'b1, 1'b0, 8'h30, 32'h0, 32'hA5A5_0F0F, 1'b1);
    slverr_inj = 1'b0;
  endtask

  task automatic test_timeout();
    int  acc;
    bit  got;
    stall = 1'b1;
    sb.push_back('{1'b0, 32'h0, 1'b1});
    drive_req(1'b0, 1'b0, 8'h05, 32'h0);
    @(negedge pclk_i);
    req0_i = 1'b0;
    n_cmp++;
    if (gnt0_o !== 1'b1) begin
      n_err++;
      $display("FAIL to_gnt: gnt0=%b, required 1", gnt0_o);
    end
    acc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge pclk_i);
      if (psel_o && penable_o) acc++;
      if (done0_o) got = 1'b1;
    end
    n_cmp++;
    if (!got || acc != 16) begin
      n_err++;
      $display("FAIL to_cycles: done=%b after %0d ACCESS cycles, required 1 after 16", got, acc);
    end
    n_cmp++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0) begin
      n_err++;
      $display("FAIL to_release: psel=%b penable=%b at done, required 0 0", psel_o, penable_o);
    end
    stall = 1'b0;
    @(negedge pclk_i);
  endtask

  task automatic test_mid_reset();
    bit got;
    stall = 1'b1;
    drive_req(1'b0, 1'b0, 8'h10, 32'h0);
    @(negedge pclk_i);
    req0_i = 1'b0;
    @(negedge pclk_i);
    @(negedge pclk_i);
    n_cmp++;
    if (psel_o !== 1'b1 || penable_o !== 1'b1) begin
      n_err++;
      $display("FAIL mr_in_access: psel=%b penable=%b, required 1 1", psel_o, penable_o);
    end
    drive_req(1'b1, 1'b1, 8'h44, 32'h0BAD_F00D);
    #2 prst_i = 1'b1;
    #1;
    n_cmp++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0) begin
      n_err++;
      $display("FAIL mr_async: psel=%b penable=%b right after reset, required 0 0", psel_o, penable_o);
    end
    @(negedge pclk_i);
    n_cmp++;
    if ({done0_o, done1_o, gnt0_o, gnt1_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL mr_quiet: done0/done1/gnt0/gnt1=%b in reset, required 0000",
               {done0_o, done1_o, gnt0_o, gnt1_o});
    end
    stall = 1'b0;
    sb.push_back('{1'b1, 32'h0, 1'b0});
    prst_i = 1'b0;
    @(negedge pclk_i);
    req1_i = 1'b0;
    n_cmp++;
    if ({gnt0_o, gnt1_o} !== 2'b01) begin
      n_err++;
      $display("FAIL mr_regrant: gnt0/gnt1=%b, required 01", {gnt0_o, gnt1_o});
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge pclk_i);
      if (done1_o) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL mr_done: no done1 after regrant within 10 cycles");
    end
    run_xfer(1'b0, 1'b0, 8'h44, 32'h0, 32'h0BAD_F00D, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_simultaneous();
    test_fairness();
    test_slave_error();
    test_timeout();
    test_mid_reset();
    repeat (3) @(negedge pclk_i);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drained: %0d expected completions never arrived, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
